// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared types, sizing helpers and prefix operator for the Brent-Kung front end
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int log2ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int nl_of(input int n);
    return 2 * log2ceil(n) - 1;
  endfunction

  function automatic int ns_of(input int n, input int lps);
    return (nl_of(n) + lps - 1) / lps;
  endfunction

  // hi is the more significant group, lo the adjacent lower one
  function automatic pg_t pg_op(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// rtl/bk_prefix_level.sv - one combinational Brent-Kung level over indices 0..N
module bk_prefix_level
  import bk_pkg::*;
#(
  parameter int N     = 64,
  parameter int LEVEL = 0
) (
  input  logic [N:0] g_i,
  input  logic [N:0] p_i,
  output logic [N:0] g_o,
  output logic [N:0] p_o
);

  localparam int M    = log2ceil(N);
  localparam bit UP   = (LEVEL < M);
  localparam int DK   = UP ? 0 : (2 * M - 2 - LEVEL);
  localparam int SPAN = 1 << (UP ? LEVEL : DK);

  for (genvar i = 0; i <= N; i++) begin : g_idx
    // up-sweep closes aligned blocks; down-sweep fills the odd midpoints from below
    localparam bit ACT = UP ? (((i + 1) % (2 * SPAN)) == 0)
                            : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
    if (ACT) begin : g_op
      pg_t hi, lo, r;
      assign hi = {g_i[i], p_i[i]};
      assign lo = {g_i[i-SPAN], p_i[i-SPAN]};
      assign r  = pg_op(hi, lo);
      assign g_o[i] = r.g;
      assign p_o[i] = r.p;
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/bk_prefix_pipe.sv
// rtl/bk_prefix_pipe.sv - elastic pipelined Brent-Kung P/G front end for the sum stage
module bk_prefix_pipe
  import bk_pkg::*;
#(
  parameter int N   = 64,
  parameter int LPS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   p,
  output logic [N:0]   g
);

  localparam int NL = nl_of(N);
  localparam int NS = ns_of(N, LPS);

  logic [N:0] g_q  [NS+1];
  logic [N:0] g_d  [NS+1];
  logic [N:0] pb_q [NS+1];
  logic [N:0] pb_d [NS+1];
  logic [N:0] pp_q [NS];
  logic [N:0] pp_d [NS];
  logic [NS:0] v_q;
  logic [NS:0] v_in;
  logic [NS:0] ld;

  always_comb begin
    logic chain;
    ld    = '0;
    chain = !v_q[NS] | out_ready;
    ld[NS] = chain;
    for (int k = NS - 1; k >= 0; k--) begin
      chain = !v_q[k] | chain;
      ld[k] = chain;
    end
  end

  assign in_ready = ld[0];
  assign v_in     = {v_q[NS-1:0], in_valid};

  assign g_d[0]  = {a & b, cin};
  assign pp_d[0] = {a ^ b, 1'b0};
  assign pb_d[0] = {a ^ b, 1'b0};

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    logic [N:0] gin, pin, gout, pout;
    if (l % LPS == 0) begin : g_from_reg
      assign gin = g_q[l/LPS];
      assign pin = pp_q[l/LPS];
    end else begin : g_chain
      assign gin = g_lvl[l-1].gout;
      assign pin = g_lvl[l-1].pout;
    end
    bk_prefix_level #(.N(N), .LEVEL(l)) u_level (
      .g_i(gin), .p_i(pin), .g_o(gout), .p_o(pout)
    );
    // group P is dead after the final level
    if (l == NL - 1) begin : g_sink
      logic unused_p;
      assign unused_p = ^pout;
    end
  end

  for (genvar k = 1; k <= NS; k++) begin : g_stage
    localparam int LAST = ((k * LPS < NL) ? k * LPS : NL) - 1;
    assign g_d[k]  = g_lvl[LAST].gout;
    assign pb_d[k] = pb_q[k-1];
    if (k < NS) begin : g_pp
      assign pp_d[k] = g_lvl[LAST].pout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k <= NS; k++) begin
        g_q[k]  <= '0;
        pb_q[k] <= '0;
      end
      for (int k = 0; k < NS; k++) pp_q[k] <= '0;
    end else begin
      for (int k = 0; k <= NS; k++) begin
        if (ld[k]) begin
          v_q[k]  <= v_in[k];
          g_q[k]  <= g_d[k];
          pb_q[k] <= pb_d[k];
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (ld[k]) pp_q[k] <= pp_d[k];
      end
    end
  end

  assign out_valid = v_q[NS];
  assign p         = pb_q[NS];
  assign g         = g_q[NS];

endmodule

// File: tb/tb_bk_prefix_pipe.sv
// tb/tb_bk_prefix_pipe.sv - directed and streamed checks of bk_prefix_pipe with a chained sum stage
module tb_bk_prefix_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic [63:0] a, b;
  logic [64:0] p, g;

  bk_prefix_pipe #(.N(64), .LPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .g(g)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a, b;
    logic        cin;
    logic [63:0] es;
    logic        ec;
    bit          he;
    int          acc;
  } word_t;

  typedef struct {
    logic [63:0] a, b;
    logic        cin;
    logic [63:0] es;
    logic        ec;
    logic [64:0] eg;
  } vec_t;

  word_t q[$];
  int    oc[$];
  bit    lat_on = 1'b0;
  vec_t  tbl[8];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] ripple_g(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] r;
    logic        cc;
    cc   = c;
    r[0] = cc;
    for (int j = 0; j < 64; j++) begin
      cc     = (x[j] & y[j]) | ((x[j] ^ y[j]) & cc);
      r[j+1] = cc;
    end
    return r;
  endfunction

  function automatic logic [63:0] sum_of(input logic [64:0] pv, input logic [64:0] gv);
    logic [63:0] s;
    for (int j = 0; j < 64; j++) s[j] = pv[j+1] ^ gv[j];
    return s;
  endfunction

  // scoreboard: every delivered word is checked in order against what was accepted
  logic        prev_stall = 1'b0;
  logic [64:0] prev_p, prev_g;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_p", p, prev_p);
        chk("hold_g", g, prev_g);
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = p;
      prev_g     = g;
      if (out_valid && out_ready) begin
        oc.push_back(cyc);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out actual=word required=none g=%h", g);
        end else begin
          word_t       w;
          logic [64:0] ex;
          w  = q.pop_front();
          ex = {1'b0, w.a} + {1'b0, w.b} + {64'd0, w.cin};
          chk("p", p, {w.a ^ w.b, 1'b0});
          chk("g", g, ripple_g(w.a, w.b, w.cin));
          chk("sum", sum_of(p, g), ex[63:0]);
          chk("cout", g[64], ex[64]);
          if (w.he) begin
            chk("hand_sum", sum_of(p, g), w.es);
            chk("hand_cout", g[64], w.ec);
          end
          if (lat_on) chk("latency", cyc - w.acc, 4);
        end
      end
    end
  end

  task automatic try_send(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                          input logic [63:0] es, input logic ec, input bit he, output bit acc);
    word_t w;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    #1;
    acc = in_ready;
    if (acc) begin
      w.a = av; w.b = bv; w.cin = cv; w.es = es; w.ec = ec; w.he = he; w.acc = cyc;
      q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                      input logic [63:0] es, input logic ec, input bit he, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      try_send(av, bv, cv, es, ec, he, acc);
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=%0d required=accepted", tries);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          tries, stalls, idx, n;
    bit          acc;
    logic [63:0] bpa[8], bpb[8];
    logic        bpc[8];

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, {65{1'b1}}};
    tbl[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 65'h1_0000_0000_0000_0000};
    tbl[2] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 65'hE};
    tbl[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 65'h0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {65{1'b1}}};
    tbl[5] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65'h0};
    tbl[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFE};
    tbl[7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, {65{1'b1}}};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_p", p, 0);
    chk("rst_g", g, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; lat_on = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].es, tbl[i].ec, 1'b1, tries);
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        #3;
        n++;
      end
      chk("tbl_valid", out_valid, 1);
      chk("tbl_p", p, {tbl[i].a ^ tbl[i].b, 1'b0});
      chk("tbl_g", g, tbl[i].eg);
      chk("tbl_sum", sum_of(p, g), tbl[i].es);
      chk("tbl_cout", g[64], tbl[i].ec);
      @(negedge clk);
    end
    wait_drain();

    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 64'h0, 1'b0, 1'b0, tries);
      if (tries != 1) stalls++;
    end
    chk("stream_stalls", stalls, 0);
    wait_drain();

    lat_on = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bpa[i] = {$urandom, $urandom};
      bpb[i] = {$urandom, $urandom};
      bpc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      try_send(bpa[idx], bpb[idx], bpc[idx], 64'h0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    #1;
    chk("bp_accepted", idx, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      out_ready = c[0];
      if (idx < 8) begin
        try_send(bpa[idx], bpb[idx], bpc[idx], 64'h0, 1'b0, 1'b0, acc);
        if (acc) idx++;
      end else begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("bp_all_sent", idx, 8);

    lat_on = 1'b1;
    oc.delete();
    send(64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b1, tries);
    @(negedge clk);
    @(negedge clk);
    send(64'hFFFF_0000, 64'h0001_0000, 1'b1, 64'h1_0000_0001, 1'b0, 1'b1, tries);
    wait_drain();
    chk("bubble_count", oc.size(), 2);
    if (oc.size() == 2) chk("bubble_gap", oc[1] - oc[0], 3);

    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 64'h0, 1'b0, 1'b0, tries);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_g", g, 0);
    q.delete();
    oc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b1, tries);
    wait_drain();
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("post_rst_single", oc.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
